sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, occupancy count, sticky overflow/underflow error flags and synchronous flush. It is the single-clock-domain successor to the team's dual-clock FIFO, used wherever producer and consumer share one clock. It provides flow-control headroom and diagnostic status that the dual-clock FIFO does not have. A compile-time switch selects standard or first-word-fall-through read mode.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of 2, ≥4
- AF_LEVEL, 12, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush; empties FIFO and clears error flags
- wr_rq  in  1  write request
- wdata  in  WIDTH  write data, sampled on accepted write
- rd_rq  in  1  read request (in FWFT mode, acknowledge of head word)
- rdata  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write requested while full
- underflow  out  1  sticky: read requested while empty

## Operation
- Storage: DEPTH×WIDTH register array. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write accepted iff wr_rq && !full. The word is stored at wr_ptr and wr_ptr increments.
- Read accepted iff rd_rq && !empty. rd_ptr increments.
- Acceptance uses the flags from before the edge:
  - Write and read together while full: only the read is accepted.
  - Write and read together while empty: only the write is accepted.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both or neither are accepted.
- Status flags are decoded combinationally from the registered count, so they change only after a clock edge.
- Error flags:
  - overflow is set on any edge with wr_rq && full.
  - underflow is set on any edge with rd_rq && empty.
  - Both hold until clr or reset.
  - A rejected request has no other effect.
- clr has priority over wr_rq and rd_rq in the same cycle:
  - Pointers and count go to 0; overflow and underflow go to 0.
  - Memory contents are not cleared.
  - rdata follows the reset rule for the active mode.
- Reset values (on rst_n low, immediately): pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (AF_LEVEL ≥1), overflow 0, underflow 0, rdata 0.
- Reset asserted mid-operation discards all contents; no partial write completes.

## Timing
- Standard mode:
  - rdata is registered. For an accepted read at edge N, the word is valid on rdata after edge N (read latency 1).
  - rdata holds its value when no read is accepted.
- FWFT mode:
  - rdata shows the head word combinationally whenever !empty, so data is available with latency 0 relative to empty low.
  - rdata is 0 while empty.
  - An accepted read at edge N presents the next word, or 0 if the FIFO becomes empty, after edge N.
- Write-to-visible latency: a write at edge N deasserts empty after edge N. In FWFT mode that word appears on rdata in the same cycle.
- Full asserts after the edge that accepts the DEPTH-th outstanding write, and deasserts after the edge of the next accepted read.
- Sustained simultaneous write and read at any 0 < count < DEPTH gives one word per cycle of throughput with count constant.

## Configuration
- FIFO_FWFT_EN:
  - Defined: first-word-fall-through read mode as described above.
  - Undefined (default): standard registered read with latency 1.
- All other behaviour is identical between the two modes.

## Test plan
- Reset, then write 0x00..0x0F on 16 consecutive cycles:
  - almost_full rises after the 12th write.
  - full rises after the 16th write; count=16.
  - A 17th write sets overflow, and 0x0F is not overwritten.
- From full, read 16 times:
  - rdata sequence is 0x00..0x0F, with the expected latency for the compiled mode.
  - almost_empty rises at count=4; empty rises at count=0.
  - A further rd_rq sets underflow.
- With count=8, assert wr_rq and rd_rq together for 40 cycles with incrementing data:
  - count stays 8.
  - Data comes out in order with no gaps across pointer wrap-around.
- Simultaneous wr_rq/rd_rq at empty:
  - count becomes 1 and rdata is unchanged in standard mode.
  - Simultaneous wr_rq/rd_rq at full: count becomes 15 and overflow stays 0.
- With count=5 and overflow set, pulse clr together with wr_rq=1:
  - count becomes 0, empty=1, overflow=0, and the write is discarded.
- Drop rst_n asynchronously mid-burst at count=7:
  - All outputs take their reset values before the next clk edge.
  - After release, the first write/read returns the newly written word.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
// Single-clock FIFO with programmable almost-full / almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and synchronous flush.
//
// Compile-time option:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through: rdata shows the head
//                              word combinationally whenever the FIFO is not
//                              empty, and 0 while empty.
//                 undefined -> standard mode: rdata is registered and updated
//                              one edge after an accepted read (default).
//
// Parameters:
//   WIDTH     data word width
//   DEPTH     number of entries (power of 2, >= 4)
//   AF_LEVEL  almost_full  when count >= AF_LEVEL
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clr          synchronous flush (pointers, count, error flags)
//   wr_rq/wdata  write request and data
//   rd_rq        read request (head acknowledge in FWFT mode)
//   rdata        read data
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow                             sticky error flags
// ---------------------------------------------------------------------------
module sync_fifo_prog #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_rq,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_rq,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic             unf_q;
  logic             wr_acc;
  logic             rd_acc;

  // Status is decoded from the registered count only, so every flag moves
  // strictly after a clock edge.
  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);
  assign count        = cnt;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Acceptance uses pre-edge flags: at full only the read wins, at empty
  // only the write wins.
  assign wr_acc = wr_rq && !full;
  assign rd_acc = rd_rq && !empty;

  // Storage has no reset; rst_n gating keeps an edge seen during reset from
  // landing a write, and clr discards a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc && !clr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_rq && full)  ovf_q <= 1'b1;
      if (rd_rq && empty) unf_q <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; forced to 0 while empty.
  assign rdata = empty ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] rdata_q;

  // Registered read port; holds unless a read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (clr) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      rdata_q <= mem[rd_ptr];
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wr_rq;
  logic [7:0] wdata;
  logic       rd_rq;
  logic [7:0] rdata;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_rq(wr_rq), .wdata(wdata),
    .rd_rq(rd_rq), .rdata(rdata), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  typedef struct {
    logic       wr, rd, cl;
    logic [7:0] d;
    int         cnt;
    logic       emp, ful, af, ae, ovf, unf;
    logic [7:0] rd_exp;
  } vec_t;

  vec_t vecs [35];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: drive, take the edge, sample 1 ns later.
  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr_rq = w; rd_rq = r; clr = c; wdata = d;
    @(posedge clk);
    #1;
    wr_rq = 1'b0; rd_rq = 1'b0; clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_ae"}, almost_empty, 1);
    check({tag, "_af"}, almost_full, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_unf"}, underflow, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_rq = 1'b0; rd_rq = 1'b0; wdata = '0;

    // Fill 0x00..0x0F, overflowing write, drain, underflowing read, flush.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{wr:1, rd:0, cl:0, d:8'(i), cnt:i+1, emp:0, ful:(i == 15),
                  af:(i+1 >= 12), ae:(i+1 <= 4), ovf:0, unf:0, rd_exp:8'h00};
    end
    vecs[16] = '{wr:1, rd:0, cl:0, d:8'hAA, cnt:16, emp:0, ful:1, af:1, ae:0,
                 ovf:1, unf:0, rd_exp:8'h00};
    for (int j = 0; j < 16; j++) begin
      vecs[17+j] = '{wr:0, rd:1, cl:0, d:8'h00, cnt:15-j, emp:(j == 15), ful:0,
                     af:(15-j >= 12), ae:(15-j <= 4), ovf:1, unf:0,
                     rd_exp: FWFT ? ((j == 15) ? 8'h00 : 8'(j+1)) : 8'(j)};
    end
    vecs[33] = '{wr:0, rd:1, cl:0, d:8'h00, cnt:0, emp:1, ful:0, af:0, ae:1,
                 ovf:1, unf:1, rd_exp: FWFT ? 8'h00 : 8'h0F};
    vecs[34] = '{wr:0, rd:0, cl:1, d:8'h00, cnt:0, emp:1, ful:0, af:0, ae:1,
                 ovf:0, unf:0, rd_exp:8'h00};

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 35; k++) begin
      step(vecs[k].wr, vecs[k].rd, vecs[k].cl, vecs[k].d);
      check($sformatf("v%0d_count", k), count, vecs[k].cnt);
      check($sformatf("v%0d_empty", k), empty, vecs[k].emp);
      check($sformatf("v%0d_full", k), full, vecs[k].ful);
      check($sformatf("v%0d_af", k), almost_full, vecs[k].af);
      check($sformatf("v%0d_ae", k), almost_empty, vecs[k].ae);
      check($sformatf("v%0d_ovf", k), overflow, vecs[k].ovf);
      check($sformatf("v%0d_unf", k), underflow, vecs[k].unf);
      check($sformatf("v%0d_rdata", k), rdata, vecs[k].rd_exp);
    end

    // Steady state at count=8 through pointer wrap-around.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 8'(k));
    check("steady_pre_count", count, 8);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8 + i));
      check($sformatf("steady%0d_count", i), count, 8);
      check($sformatf("steady%0d_rdata", i), rdata, FWFT ? (i + 1) : i);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Simultaneous request at empty: only the write lands.
    step(1'b1, 1'b1, 1'b0, 8'h55);
    check("wr_rd_empty_count", count, 1);
    check("wr_rd_empty_rdata", rdata, FWFT ? 8'h55 : 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Simultaneous request at full: only the read lands.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + k));
    check("fill2_full", full, 1);
    step(1'b1, 1'b1, 1'b0, 8'h99);
    check("wr_rd_full_count", count, 15);
    check("wr_rd_full_rdata", rdata, FWFT ? 8'h11 : 8'h10);
    check("wr_rd_full_full", full, 0);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // count=5 with overflow set, then clr with a concurrent write.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0, 8'(8'h20 + k));
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    for (int k = 0; k < 11; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("pre_clr_count", count, 5);
    check("pre_clr_ovf", overflow, 1);
    step(1'b1, 1'b0, 1'b1, 8'h77);
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    check("clr_ovf", overflow, 0);
    check("clr_rdata", rdata, 0);
    step(1'b1, 1'b0, 1'b0, 8'h33);
    check("post_clr_count", count, 1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("post_clr_rdata", rdata, FWFT ? 8'h00 : 8'h33);
    check("post_clr_empty", empty, 1);

    // Asynchronous reset mid-burst at count=7.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 8'(8'hE0 + k));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("pre_rst_count", count, 7);
    check("pre_rst_rdata", rdata, FWFT ? 8'hE1 : 8'hE0);
    wr_rq = 1'b1; wdata = 8'hF0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    wr_rq = 1'b0;
    @(posedge clk); @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'hC3);
    check("after_rst_count", count, 1);
    check("after_rst_fwft", rdata, FWFT ? 8'hC3 : 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("after_rst_rdata", rdata, FWFT ? 8'h00 : 8'hC3);
    check("after_rst_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
